move_sched: RTL and testbench
=============================

MOVE_SCHED -- requirements
Module: move_sched

Interface
REQ-001 The block SHALL have parameter GRAVITY_FRAMES, default 30: number of completed frames between automatic gravity drops (legal range 2..255).
REQ-002 The block SHALL have parameter DONE_TIMEOUT, default 1023: maximum vga_clk cycles to wait for op_done (legal range 1..1023).
REQ-003 The block SHALL have port vga_clk, input, 1 bit: the single clock; all logic is rising-edge on it.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port op_keys, input, 4 bits: single-cycle key pulses; [0] rotate, [1] down, [2] left, [3] right.
REQ-006 The block SHALL have port draw_finish, input, 1 bit: one-cycle pulse at end of each displayed frame.
REQ-007 The block SHALL have port op_valid, output, 1 bit: grid operation request.
REQ-008 The block SHALL have port op_code, output, 3 bits: 0 NOP, 1 ROTATE, 2 DOWN, 3 LEFT, 4 RIGHT, 5 GRAVITY, 6 SPAWN.
REQ-009 The block SHALL have port op_ready, input, 1 bit: grid controller accepts the request.
REQ-010 The block SHALL have port op_done, input, 1 bit: one-cycle pulse when the accepted op has been applied.
REQ-011 The block SHALL have port op_landed, input, 1 bit: qualified by op_done; the piece landed.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-013 The block SHALL have port timeout_err, output, 1 bit: sticky flag set on op_done timeout.

Function
REQ-014 The block SHALL hold one pending bit per source: rotate, down, left, right, gravity, spawn.
REQ-015 An op_keys[i] pulse SHALL set its pending bit; a pulse on an already pending key SHALL coalesce with no further effect.
REQ-016 If a set and an issue-clear of the same pending bit occur in the same cycle, the set SHALL win and the bit SHALL remain pending.
REQ-017 An 8-bit frame counter SHALL increment on each draw_finish; on reaching GRAVITY_FRAMES-1 it SHALL wrap to 0 and set gravity pending in that cycle.
REQ-018 Acceptance of a DOWN op SHALL clear the frame counter to 0; a DOWN op and a GRAVITY op SHALL never both be issued within one frame.
REQ-019 Issue priority SHALL be SPAWN > ROTATE > LEFT > RIGHT > DOWN > GRAVITY, and at most one op SHALL be issued per frame.
REQ-020 The FSM SHALL have states IDLE, ISSUE and WAIT_DONE.
REQ-021 In IDLE, when draw_finish=1 and any bit is pending, the FSM SHALL latch the winner into op_code and enter ISSUE on the next cycle; otherwise it SHALL stay in IDLE.
REQ-022 In ISSUE, op_valid=1 and op_code SHALL remain stable until op_valid&op_ready; on that cycle the winner's pending bit SHALL clear and the FSM SHALL enter WAIT_DONE.
REQ-023 In WAIT_DONE, when op_done=1 the FSM SHALL return to IDLE; if op_landed=1 it SHALL also set spawn pending and clear gravity pending.
REQ-024 A 10-bit timer SHALL run in WAIT_DONE; if it reaches DONE_TIMEOUT without op_done, timeout_err SHALL set and the FSM SHALL go to IDLE.
REQ-025 A draw_finish outside IDLE SHALL still advance the frame counter but SHALL NOT create an issue slot.
REQ-026 op_valid SHALL be 0 and op_code SHALL be 0 whenever the FSM is not in ISSUE.
REQ-027 An op_done that arrives outside WAIT_DONE SHALL be ignored.

Reset
REQ-028 Asserting reset SHALL asynchronously force IDLE, all pending bits to 0, frame counter and timer to 0, op_valid=0, op_code=0, busy=0 and timeout_err=0.
REQ-029 Reset asserted mid-handshake SHALL abandon the op with no replay; deassertion SHALL be synchronised to vga_clk.

Structure
REQ-030 The op_code encodings, the FSM state encoding and the key bit indices SHALL reside in the shared tetris package (tetris_pkg) used by GRID_CTRL.
REQ-031 The priority selection SHALL be one sub-module, move_prio_enc (6 pending bits in, 3-bit op_code out), with all remaining logic inline.

Verification
REQ-032 Scenario: pulse op_keys=4'b0100, then draw_finish, with op_ready tied 1 -> ISSUE one cycle after draw_finish, op_code=3, then op_done -> IDLE.
REQ-033 Scenario: pulse rotate and right in the same cycle, then two frames -> ROTATE (1) in frame 1, RIGHT (4) in frame 2.
REQ-034 Scenario: GRAVITY_FRAMES=4, no keys -> GRAVITY (5) issued every 4th draw_finish; a DOWN accepted at frame 2 -> next GRAVITY at frame 6.
REQ-035 Scenario: op_done with op_landed=1 -> next issued op is SPAWN (6), even with left pending.
REQ-036 Scenario: op_done withheld -> timeout_err=1 after 1023 WAIT_DONE cycles and FSM in IDLE; reset -> timeout_err=0.
REQ-037 Scenario: reset asserted while op_valid=1 -> op_valid=0 immediately (asynchronous), pending bits 0.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared tetris definitions: grid op codes, move scheduler state encoding,
// key bit indices and pending-bit layout.
package tetris_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } sched_state_e;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_ROTATE  = 3'd1,
        OP_DOWN    = 3'd2,
        OP_LEFT    = 3'd3,
        OP_RIGHT   = 3'd4,
        OP_GRAVITY = 3'd5,
        OP_SPAWN   = 3'd6
    } op_code_e;

    localparam int KEY_ROTATE = 0;
    localparam int KEY_DOWN   = 1;
    localparam int KEY_LEFT   = 2;
    localparam int KEY_RIGHT  = 3;

    localparam int PEND_W       = 6;
    localparam int PEND_ROTATE  = 0;
    localparam int PEND_DOWN    = 1;
    localparam int PEND_LEFT    = 2;
    localparam int PEND_RIGHT   = 3;
    localparam int PEND_GRAVITY = 4;
    localparam int PEND_SPAWN   = 5;

    // One-hot pending mask owned by a given op code (empty for NOP/unknown).
    function automatic logic [PEND_W-1:0] op_to_pend_mask(input logic [2:0] op);
        logic [PEND_W-1:0] mask;
        mask = '0;
        case (op)
            OP_ROTATE:  mask[PEND_ROTATE]  = 1'b1;
            OP_DOWN:    mask[PEND_DOWN]    = 1'b1;
            OP_LEFT:    mask[PEND_LEFT]    = 1'b1;
            OP_RIGHT:   mask[PEND_RIGHT]   = 1'b1;
            OP_GRAVITY: mask[PEND_GRAVITY] = 1'b1;
            OP_SPAWN:   mask[PEND_SPAWN]   = 1'b1;
            default:    mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/move_prio_enc.sv
// Fixed-priority selector over the pending sources:
// SPAWN > ROTATE > LEFT > RIGHT > DOWN > GRAVITY.
module move_prio_enc
    import tetris_pkg::*;
(
    input  logic [PEND_W-1:0] pend,
    output logic [2:0]        code
);

    always_comb begin
        code = OP_NOP;
        if (pend[PEND_SPAWN])
            code = OP_SPAWN;
        else if (pend[PEND_ROTATE])
            code = OP_ROTATE;
        else if (pend[PEND_LEFT])
            code = OP_LEFT;
        else if (pend[PEND_RIGHT])
            code = OP_RIGHT;
        else if (pend[PEND_DOWN])
            code = OP_DOWN;
        else if (pend[PEND_GRAVITY])
            code = OP_GRAVITY;
    end

endmodule

// File: rtl/move_sched.sv
// Move scheduler: collects key/gravity/spawn requests and issues at most one
// grid operation per displayed frame, with a done-timeout watchdog.
module move_sched
    import tetris_pkg::*;
#(
    parameter int GRAVITY_FRAMES = 30,
    parameter int DONE_TIMEOUT   = 1023
)
(
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [3:0] op_keys,
    input  logic       draw_finish,
    output logic       op_valid,
    output logic [2:0] op_code,
    input  logic       op_ready,
    input  logic       op_done,
    input  logic       op_landed,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [7:0] GRAV_LAST = 8'(GRAVITY_FRAMES - 1);
    localparam logic [9:0] DONE_LAST = 10'(DONE_TIMEOUT - 1);

    // Assert immediately, release two clocks after reset drops.
    logic [1:0] rst_sync;
    logic       rst;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset)
            rst_sync <= 2'b11;
        else
            rst_sync <= {rst_sync[0], 1'b0};
    end

    assign rst = rst_sync[1];

    sched_state_e      state, state_nxt;
    logic [2:0]        op_code_q;
    logic [PEND_W-1:0] pend_q, pend_set, pend_clr, pend_eff, pend_nxt;
    logic [7:0]        frame_cnt;
    logic [9:0]        timer;
    logic              timeout_q;
    logic [2:0]        win_code;

    logic issue_acc, down_acc, grav_wrap, done_ok, timed_out, slot_open;

    assign issue_acc = (state == ST_ISSUE) && op_ready;
    assign down_acc  = issue_acc && (op_code_q == OP_DOWN);
    assign grav_wrap = draw_finish && !down_acc && (frame_cnt == GRAV_LAST);
    assign done_ok   = (state == ST_WAIT_DONE) && op_done;
    assign timed_out = (state == ST_WAIT_DONE) && !op_done && (timer == DONE_LAST);

    always_comb begin
        pend_set               = '0;
        pend_set[PEND_ROTATE]  = op_keys[KEY_ROTATE];
        pend_set[PEND_DOWN]    = op_keys[KEY_DOWN];
        pend_set[PEND_LEFT]    = op_keys[KEY_LEFT];
        pend_set[PEND_RIGHT]   = op_keys[KEY_RIGHT];
        pend_set[PEND_GRAVITY] = grav_wrap;
        pend_set[PEND_SPAWN]   = done_ok && op_landed;
    end

    // A DOWN drop or a landing makes any queued gravity drop stale.
    always_comb begin
        pend_clr = '0;
        if (issue_acc)
            pend_clr = op_to_pend_mask(op_code_q);
        if (down_acc || (done_ok && op_landed))
            pend_clr[PEND_GRAVITY] = 1'b1;
    end

    // Sets win over clears, and same-cycle requests compete for this frame.
    assign pend_nxt  = (pend_q & ~pend_clr) | pend_set;
    assign pend_eff  = pend_q | pend_set;
    assign slot_open = (state == ST_IDLE) && draw_finish && (|pend_eff);

    move_prio_enc u_prio (
        .pend (pend_eff),
        .code (win_code)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (slot_open)
                    state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (op_ready)
                    state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (op_done || timed_out)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pend_q    <= '0;
            frame_cnt <= '0;
            timer     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            pend_q <= pend_nxt;

            if (down_acc)
                frame_cnt <= '0;
            else if (draw_finish)
                frame_cnt <= grav_wrap ? 8'd0 : frame_cnt + 8'd1;

            if ((state == ST_WAIT_DONE) && (state_nxt == ST_WAIT_DONE))
                timer <= timer + 10'd1;
            else
                timer <= '0;

            if (timed_out)
                timeout_q <= 1'b1;
        end
    end

    // Latched op code is only visible while ISSUE, so it needs no reset.
    always_ff @(posedge vga_clk) begin
        if (slot_open)
            op_code_q <= win_code;
    end

    assign op_valid    = (state == ST_ISSUE);
    assign op_code     = op_valid ? op_code_q : OP_NOP;
    assign busy        = (state != ST_IDLE);
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_move_sched.sv
// Randomised and directed bench for move_sched against a frame-level
// behavioural model of the scheduling rules.
module tb_move_sched;

    localparam int GF = 4;
    localparam int DT = 1023;

    localparam int M_IDLE  = 0;
    localparam int M_ISSUE = 1;
    localparam int M_WAIT  = 2;

    logic       vga_clk = 1'b0;
    logic       reset;
    logic [3:0] op_keys;
    logic       draw_finish;
    logic       op_valid;
    logic [2:0] op_code;
    logic       op_ready;
    logic       op_done;
    logic       op_landed;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    move_sched #(
        .GRAVITY_FRAMES (GF),
        .DONE_TIMEOUT   (DT)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .op_keys     (op_keys),
        .draw_finish (draw_finish),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .op_ready    (op_ready),
        .op_done     (op_done),
        .op_landed   (op_landed),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 vga_clk = ~vga_clk;

    // Model: pending flags indexed by op code, priority as an ordered list.
    int KEY_OP[4] = '{1, 2, 3, 4};
    int PRIO[6]   = '{6, 1, 3, 4, 2, 5};
    bit m_pend[7];
    int m_mode, m_code, m_cnt, m_timer, m_hold;
    bit m_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_pend[i] = 1'b0;
        m_mode  = M_IDLE;
        m_code  = 0;
        m_cnt   = 0;
        m_timer = 0;
        m_err   = 1'b0;
        m_hold  = 2;
    endtask

    task automatic model_step();
        bit setb[7];
        bit clrb[7];
        bit down_acc;
        if (reset) return;
        if (m_hold > 0) begin
            m_hold--;
            return;
        end
        for (int i = 0; i < 7; i++) begin
            setb[i] = 1'b0;
            clrb[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++)
            if (op_keys[i]) setb[KEY_OP[i]] = 1'b1;
        down_acc = (m_mode == M_ISSUE) && op_ready && (m_code == 2);
        if (draw_finish && !down_acc && (m_cnt == GF - 1)) setb[5] = 1'b1;
        if (down_acc) m_cnt = 0;
        else if (draw_finish) m_cnt = (m_cnt + 1) % GF;
        case (m_mode)
            M_IDLE: begin
                if (draw_finish) begin
                    for (int p = 0; p < 6; p++) begin
                        if (m_pend[PRIO[p]] || setb[PRIO[p]]) begin
                            m_code = PRIO[p];
                            m_mode = M_ISSUE;
                            break;
                        end
                    end
                end
            end
            M_ISSUE: begin
                if (op_ready) begin
                    clrb[m_code] = 1'b1;
                    if (m_code == 2) clrb[5] = 1'b1;
                    m_mode  = M_WAIT;
                    m_timer = 0;
                end
            end
            default: begin
                if (op_done) begin
                    m_mode = M_IDLE;
                    if (op_landed) begin
                        setb[6] = 1'b1;
                        clrb[5] = 1'b1;
                    end
                end else if (m_timer == DT - 1) begin
                    m_err  = 1'b1;
                    m_mode = M_IDLE;
                end else begin
                    m_timer++;
                end
            end
        endcase
        for (int i = 1; i < 7; i++)
            m_pend[i] = (m_pend[i] && !clrb[i]) || setb[i];
    endtask

    task automatic compare();
        check_val("op_valid", 32'(op_valid), 32'(m_mode == M_ISSUE));
        check_val("op_code", 32'(op_code), (m_mode == M_ISSUE) ? 32'(m_code) : 32'd0);
        check_val("busy", 32'(busy), 32'(m_mode != M_IDLE));
        check_val("timeout_err", 32'(timeout_err), 32'(m_err));
    endtask

    task automatic cycle(input logic [3:0] k, input logic df, input logic rdy,
                         input logic dn, input logic ld);
        @(negedge vga_clk);
        op_keys     = k;
        draw_finish = df;
        op_ready    = rdy;
        op_done     = dn;
        op_landed   = ld;
        @(posedge vga_clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic assert_reset();
        @(negedge vga_clk);
        reset       = 1'b1;
        op_keys     = 4'd0;
        draw_finish = 1'b0;
        op_ready    = 1'b0;
        op_done     = 1'b0;
        op_landed   = 1'b0;
        model_reset();
        #1;
        compare();
    endtask

    task automatic release_reset();
        @(negedge vga_clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        assert_reset();
        release_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset       = 1'b1;
        op_keys     = 4'd0;
        draw_finish = 1'b0;
        op_ready    = 1'b0;
        op_done     = 1'b0;
        op_landed   = 1'b0;
        model_reset();
        do_reset();
        check_val("rst_valid", 32'(op_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);

        // Single LEFT key, ready tied high.
        cycle(4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("s32_valid", 32'(op_valid), 32'd1);
        check_val("s32_code", 32'(op_code), 32'd3);
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("s32_wait", 32'(busy), 32'd1);
        cycle(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("s32_idle", 32'(busy), 32'd0);

        // Rotate and right together: two frames, two ops.
        do_reset();
        cycle(4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("s33_first", 32'(op_code), 32'd1);
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("s33_second", 32'(op_code), 32'd4);
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);

        // Gravity every 4th frame with no keys.
        do_reset();
        for (int f = 1; f <= 3; f++) begin
            cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
            check_val("s34_nograv", 32'(op_valid), 32'd0);
        end
        cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("s34_grav4", 32'(op_code), 32'd5);
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);

        // DOWN accepted at frame 2 restarts the gravity interval.
        do_reset();
        cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("s34_down", 32'(op_code), 32'd2);
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int f = 3; f <= 5; f++) begin
            cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
            check_val("s34_quiet", 32'(op_valid), 32'd0);
        end
        cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("s34_grav6", 32'(op_code), 32'd5);
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);

        // Landing forces SPAWN ahead of a pending LEFT.
        do_reset();
        cycle(4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("s35_rot", 32'(op_code), 32'd1);
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("s35_spawn", 32'(op_code), 32'd6);
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("s35_left", 32'(op_code), 32'd3);
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);

        // op_done withheld until the watchdog fires.
        do_reset();
        cycle(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (!timeout_err && n < 1100) begin
            cycle(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        check_val("s36_cycles", 32'(n), 32'd1023);
        check_val("s36_err", 32'(timeout_err), 32'd1);
        check_val("s36_idle", 32'(busy), 32'd0);
        do_reset();
        check_val("s36_clr", 32'(timeout_err), 32'd0);

        // Reset mid-handshake drops op_valid without waiting for a clock.
        cycle(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("s37_pre", 32'(op_valid), 32'd1);
        assert_reset();
        check_val("s37_valid", 32'(op_valid), 32'd0);
        check_val("s37_code", 32'(op_code), 32'd0);
        release_reset();
        cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("s37_nopend", 32'(op_valid), 32'd0);

        // Randomised traffic including stray op_done and occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] k;
            k = ($urandom_range(0, 6) == 0) ? 4'($urandom) : 4'd0;
            if ($urandom_range(0, 499) == 0)
                do_reset();
            else
                cycle(k, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
